// File: rtl/unidade_despacho_param.sv
// Tomasulo dispatch unit: decodes one instruction per cycle, resolves its
// operands from the register status table (with CDB bypass) and issues it to
// the lowest-numbered free reservation station. If no station is free, the
// instruction is parked in a hold register and the queue is back-pressured.

// Operand resolver for one source operand (j or k).
module disp_opnd #(
  parameter int              DATA_W = 16,
  parameter int              TAG_W  = 3,
  parameter logic [DATA_W-1:0] VOID_D = '1
) (
  input  logic [TAG_W-1:0]  reg_qi,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] v,
  output logic [TAG_W-1:0]  q
);
  // Ready in the register file, caught on the CDB this cycle, or still pending.
  always_comb begin
    v = VOID_D;
    q = reg_qi;
    if (reg_qi == '0) begin
      v = reg_val;
      q = '0;
    end else if (cdb_valid && (cdb_tag == reg_qi)) begin
      v = cdb_data;
      q = '0;
    end
  end
endmodule

module unidade_despacho_param #(
  parameter int          DATA_W     = 16,
  parameter int          NRS        = 4,
  parameter int          TAG_W      = 3,
  parameter logic [15:0] VOID_VALUE = 16'hFFF0
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Instr_Valid,
  input  logic [15:0]           Instr,
  output logic                  Instr_Ready,
  input  logic [8*TAG_W-1:0]    Reg_Qi,
  input  logic [8*DATA_W-1:0]   Reg_Data,
  input  logic [NRS-1:0]        Rs_Busy,
  input  logic                  CDB_Valid,
  input  logic [TAG_W-1:0]      CDB_Tag,
  input  logic [DATA_W-1:0]     CDB_Data,
  output logic [NRS-1:0]        Issue_En,
  output logic [DATA_W-1:0]     Vj,
  output logic [DATA_W-1:0]     Vk,
  output logic [TAG_W-1:0]      Qj,
  output logic [TAG_W-1:0]      Qk,
  output logic [2:0]            Opcode,
  output logic [2:0]            R_target,
  output logic                  RegStat_We,
  output logic [2:0]            RegStat_Reg,
  output logic [TAG_W-1:0]      RegStat_Tag,
  output logic [15:0]           Stall_Cycles
);
  localparam logic [DATA_W-1:0] VOID_D = DATA_W'(VOID_VALUE);
  localparam int NOPND = 2;  // source operands per instruction: j, k

  typedef enum logic {IDLE, HOLD} state_t;

  // Decoded fields actually used by dispatch (low nibble is unused).
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] ri;
    logic [2:0] rj;
    logic [2:0] rk;
  } dinstr_t;

  state_t  state, state_nx;
  dinstr_t hold_q, cand;
  logic    cand_vld, cand_nop;
  logic    do_issue, do_capture;

  logic [NRS-1:0]   free, alloc_oh;
  logic [TAG_W-1:0] alloc_tag;

  logic [TAG_W-1:0]  qi_arr  [8];
  logic [DATA_W-1:0] dat_arr [8];

  logic [NOPND-1:0][2:0]        src_reg;
  logic [NOPND-1:0][TAG_W-1:0]  src_qi, res_q;
  logic [NOPND-1:0][DATA_W-1:0] src_val, res_v;

  logic unused_lo;
  assign unused_lo = ^Instr[3:0];

  // Unpack the register status / data buses into per-register views.
  for (genvar r = 0; r < 8; r++) begin : g_reg
    assign qi_arr[r]  = Reg_Qi[r*TAG_W +: TAG_W];
    assign dat_arr[r] = Reg_Data[r*DATA_W +: DATA_W];
  end

  assign Instr_Ready = (state == IDLE);

  // Candidate comes from the queue in IDLE, from the hold register in HOLD.
  always_comb begin
    cand     = (state == HOLD) ? hold_q : dinstr_t'(Instr[15:4]);
    cand_vld = (state == HOLD) ? 1'b1 : Instr_Valid;
    cand_nop = (cand.op == 3'b000);
  end

  // A station is free only if not busy and not strobed last cycle, since
  // Busy from a just-loaded station may not have risen yet.
  assign free = ~Rs_Busy & ~Issue_En;

  // Lowest-index free station wins.
  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_oh  = '0;
    alloc_tag = '0;
    for (int k = 0; k < NRS; k++) begin
      if (free[k] && !found) begin
        found       = 1'b1;
        alloc_oh[k] = 1'b1;
        alloc_tag   = TAG_W'(k + 1);
      end
    end
  end

  // Operand resolution for j and k lanes.
  assign src_reg[0] = cand.rj;
  assign src_reg[1] = cand.rk;

  for (genvar i = 0; i < NOPND; i++) begin : g_opnd
    assign src_qi[i]  = qi_arr[src_reg[i]];
    assign src_val[i] = dat_arr[src_reg[i]];
    disp_opnd #(.DATA_W(DATA_W), .TAG_W(TAG_W), .VOID_D(VOID_D)) u_opnd (
      .reg_qi   (src_qi[i]),
      .reg_val  (src_val[i]),
      .cdb_valid(CDB_Valid),
      .cdb_tag  (CDB_Tag),
      .cdb_data (CDB_Data),
      .v        (res_v[i]),
      .q        (res_q[i])
    );
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and issue/capture decisions.
  always_comb begin
    state_nx   = state;
    do_issue   = 1'b0;
    do_capture = 1'b0;
    case (state)
      IDLE: begin
        if (cand_vld && !cand_nop) begin
          if (free != '0) do_issue = 1'b1;
          else begin
            do_capture = 1'b1;
            state_nx   = HOLD;
          end
        end
      end
      HOLD: begin
        if (free != '0) begin
          do_issue = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Hold register: parks a stalled instruction; discarded by reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)        hold_q <= '0;
    else if (do_capture) hold_q <= dinstr_t'(Instr[15:4]);
  end

  // Saturating stall counter, counts cycles stuck in HOLD.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) Stall_Cycles <= '0;
    else if (state == HOLD && free == '0 && Stall_Cycles != 16'hFFFF)
      Stall_Cycles <= Stall_Cycles + 16'd1;
  end

  // Issue registers: strobes pulse for one cycle, payload holds last issue.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Issue_En    <= '0;
      RegStat_We  <= 1'b0;
      Vj          <= VOID_D;
      Vk          <= VOID_D;
      Qj          <= '0;
      Qk          <= '0;
      Opcode      <= '0;
      R_target    <= '0;
      RegStat_Reg <= '0;
      RegStat_Tag <= '0;
    end else if (do_issue) begin
      Issue_En    <= alloc_oh;
      RegStat_We  <= 1'b1;
      Vj          <= res_v[0];
      Vk          <= res_v[1];
      Qj          <= res_q[0];
      Qk          <= res_q[1];
      Opcode      <= cand.op;
      R_target    <= cand.ri;
      RegStat_Reg <= cand.ri;
      RegStat_Tag <= alloc_tag;
    end else begin
      Issue_En    <= '0;
      RegStat_We  <= 1'b0;
    end
  end

endmodule
